// File: rtl/calcu16_pkg.sv
// Shared types and constants for the calcu16 memory port arbiter.
// Vectors use [0:N] numbering throughout: bit 0 is the MSB.
package calcu16_pkg;

  localparam int WORD_W       = 16;
  localparam int INSTR_W      = 26;
  // word1 bit that lands in instr[16]; word1[0:5] are dropped
  localparam int INSTR_LO_MSB = 6;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_DATA  = 0;
  localparam int GNT_FETCH = 1;

  typedef enum logic [2:0] {
    IDLE,
    D_ACC,
    D_WAIT,
    F_ACC0,
    F_WAIT0,
    F_ACC1,
    F_WAIT1,
    DONE
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: conflict resolution between fetch and data requests.
// Build option MEM_PORT_ARB_RR_EN: when defined, conflicts alternate using a
// last-grant flop; when undefined, data always beats fetch.
module mem_arb_pick
  import calcu16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       take,
  input  logic       fetch_req,
  input  logic       data_req,
  output logic [1:0] grant
);

`ifdef MEM_PORT_ARB_RR_EN
  // 1 = data won the most recent grant; resets to data so fetch wins first
  logic last_data_reg;

  // Record the winner each time the FSM accepts a grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_reg <= 1'b1;
    end else if (take) begin
      last_data_reg <= grant[GNT_DATA];
    end
  end

  // On conflict the requester not granted last wins
  always_comb begin
    grant = 2'b00;
    if (data_req && fetch_req) begin
      if (last_data_reg) grant[GNT_FETCH] = 1'b1;
      else               grant[GNT_DATA]  = 1'b1;
    end else if (data_req) begin
      grant[GNT_DATA] = 1'b1;
    end else if (fetch_req) begin
      grant[GNT_FETCH] = 1'b1;
    end
  end
`else
  // Fixed priority needs no state
  logic unused_pick;
  assign unused_pick = ^{clk, reset, take};

  // Data always beats fetch
  always_comb begin
    grant = 2'b00;
    if (data_req)       grant[GNT_DATA]  = 1'b1;
    else if (fetch_req) grant[GNT_FETCH] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 16-bit RAM between instruction
// fetch (two words -> 26-bit instruction) and a load/store path.
// All outputs are registered. Build option: MEM_PORT_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
  import calcu16_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [0:WORD_W-1]    fetch_addr,
  output logic                 fetch_done,
  output logic [0:INSTR_W-1]   fetch_instr,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [0:WORD_W-1]    data_addr,
  input  logic [0:WORD_W-1]    data_wdata,
  output logic                 data_done,
  output logic [0:WORD_W-1]    data_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [0:WORD_W-1]    mem_addr,
  output logic [0:WORD_W-1]    mem_wdata,
  input  logic [0:WORD_W-1]    mem_rdata
);

  // Latency 1 skips the wait states; otherwise wait MEM_LATENCY-1 cycles
  localparam bit         LAT1      = (MEM_LATENCY == 1);
  localparam logic [2:0] WAIT_INIT = (MEM_LATENCY > 1) ? 3'(MEM_LATENCY - 2) : 3'd0;

  state_t               state_reg, state_next;
  logic [2:0]           wait_cnt_reg, wait_cnt_next;
  logic                 we_reg, we_next;
  logic [0:WORD_W-1]    addr_reg, addr_next;
  logic [0:WORD_W-1]    wdata_reg, wdata_next;
  logic [0:WORD_W-1]    word0_reg, word0_next;
  logic [0:WORD_W-1]    data_rdata_reg, data_rdata_next;
  logic [0:INSTR_W-1]   fetch_instr_reg, fetch_instr_next;
  logic                 mem_en_reg, mem_en_next;
  logic                 mem_we_reg, mem_we_next;
  logic                 fetch_done_reg, fetch_done_next;
  logic                 data_done_reg, data_done_next;
  logic [1:0]           grant;
  logic                 take;

  assign take = (state_reg == IDLE) && (fetch_req || data_req);

  mem_arb_pick u_pick (
    .clk       (clk),
    .reset     (reset),
    .take      (take),
    .fetch_req (fetch_req),
    .data_req  (data_req),
    .grant     (grant)
  );

  // State, latched request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= 3'd0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      word0_reg       <= '0;
      data_rdata_reg  <= '0;
      fetch_instr_reg <= '0;
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      fetch_done_reg  <= 1'b0;
      data_done_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      we_reg          <= we_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      word0_reg       <= word0_next;
      data_rdata_reg  <= data_rdata_next;
      fetch_instr_reg <= fetch_instr_next;
      mem_en_reg      <= mem_en_next;
      mem_we_reg      <= mem_we_next;
      fetch_done_reg  <= fetch_done_next;
      data_done_reg   <= data_done_next;
    end
  end

  // Next state; outputs are computed one cycle ahead so they leave a flop
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    we_next          = we_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    word0_next       = word0_reg;
    data_rdata_next  = data_rdata_reg;
    fetch_instr_next = fetch_instr_reg;
    mem_en_next      = 1'b0;
    mem_we_next      = 1'b0;
    fetch_done_next  = 1'b0;
    data_done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant[GNT_DATA]) begin
          state_next  = D_ACC;
          addr_next   = data_addr;
          wdata_next  = data_wdata;
          we_next     = data_we;
          mem_en_next = 1'b1;
          mem_we_next = data_we;
        end else if (grant[GNT_FETCH]) begin
          state_next  = F_ACC0;
          addr_next   = fetch_addr;
          wdata_next  = '0;
          we_next     = 1'b0;
          mem_en_next = 1'b1;
        end
      end
      D_ACC: begin
        if (we_reg) begin
          // Posted write: nothing to wait for
          state_next     = DONE;
          data_done_next = 1'b1;
        end else if (LAT1) begin
          state_next      = DONE;
          data_done_next  = 1'b1;
          data_rdata_next = mem_rdata;
        end else begin
          state_next    = D_WAIT;
          wait_cnt_next = WAIT_INIT;
        end
      end
      D_WAIT: begin
        if (wait_cnt_reg == 3'd0) begin
          state_next      = DONE;
          data_done_next  = 1'b1;
          data_rdata_next = mem_rdata;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
      F_ACC0, F_WAIT0: begin
        if (state_reg == F_ACC0 && !LAT1) begin
          state_next    = F_WAIT0;
          wait_cnt_next = WAIT_INIT;
        end else if (state_reg == F_ACC0 || wait_cnt_reg == 3'd0) begin
          // High word captured; address wraps naturally at 16 bits
          state_next  = F_ACC1;
          word0_next  = mem_rdata;
          addr_next   = addr_reg + WORD_W'(1);
          mem_en_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
      F_ACC1, F_WAIT1: begin
        if (state_reg == F_ACC1 && !LAT1) begin
          state_next    = F_WAIT1;
          wait_cnt_next = WAIT_INIT;
        end else if (state_reg == F_ACC1 || wait_cnt_reg == 3'd0) begin
          state_next       = DONE;
          fetch_done_next  = 1'b1;
          fetch_instr_next = {word0_reg, mem_rdata[INSTR_LO_MSB:WORD_W-1]};
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fetch_done  = fetch_done_reg;
  assign fetch_instr = fetch_instr_reg;
  assign data_done   = data_done_reg;
  assign data_rdata  = data_rdata_reg;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a runs with MEM_LATENCY=1, instance b with 3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Instance a (latency 1)
  logic        a_fetch_req = 1'b0, a_data_req = 1'b0, a_data_we = 1'b0;
  logic [0:15] a_fetch_addr = '0, a_data_addr = '0, a_data_wdata = '0;
  logic        a_fetch_done, a_data_done, a_mem_en, a_mem_we;
  logic [0:25] a_fetch_instr;
  logic [0:15] a_data_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  // Instance b (latency 3)
  logic        b_fetch_req = 1'b0, b_data_req = 1'b0, b_data_we = 1'b0;
  logic [0:15] b_fetch_addr = '0, b_data_addr = '0, b_data_wdata = '0;
  logic        b_fetch_done, b_data_done, b_mem_en, b_mem_we;
  logic [0:25] b_fetch_instr;
  logic [0:15] b_data_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr),
    .fetch_done(a_fetch_done), .fetch_instr(a_fetch_instr),
    .data_req(a_data_req), .data_we(a_data_we), .data_addr(a_data_addr),
    .data_wdata(a_data_wdata), .data_done(a_data_done), .data_rdata(a_data_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr),
    .fetch_done(b_fetch_done), .fetch_instr(b_fetch_instr),
    .data_req(b_data_req), .data_we(b_data_we), .data_addr(b_data_addr),
    .data_wdata(b_data_wdata), .data_done(b_data_done), .data_rdata(b_data_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // RAM models: data is only valid for the cycle in which the DUT must capture it
  logic [0:15] ram_a [0:65535];
  logic [0:15] ram_b [0:65535];
  logic        b_v_d1 = 1'b0, b_v_d2 = 1'b0;
  logic [0:15] b_a_d1 = '0, b_a_d2 = '0;

  assign a_mem_rdata = (a_mem_en && !a_mem_we) ? ram_a[a_mem_addr] : 16'hDEAD;

  always @(posedge clk) begin
    b_v_d1 <= b_mem_en && !b_mem_we;
    b_a_d1 <= b_mem_addr;
    b_v_d2 <= b_v_d1;
    b_a_d2 <= b_a_d1;
  end
  assign b_mem_rdata = b_v_d2 ? ram_b[b_a_d2] : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({a_fetch_done, a_fetch_instr, a_data_done, a_data_rdata, a_mem_en, a_mem_we,
         a_mem_addr, a_mem_wdata} !== 78'd0) begin
      miscompares++;
      $display("FAIL reset_a: outputs not all zero (instr=%h rdata=%h en=%b)",
               a_fetch_instr, a_data_rdata, a_mem_en);
    end
    vectors++;
    if ({b_fetch_done, b_fetch_instr, b_data_done, b_data_rdata, b_mem_en, b_mem_we,
         b_mem_addr, b_mem_wdata} !== 78'd0) begin
      miscompares++;
      $display("FAIL reset_b: outputs not all zero (instr=%h rdata=%h en=%b)",
               b_fetch_instr, b_data_rdata, b_mem_en);
    end
    reset = 1'b0;
    tick();
    $display("reset applied and released");
  endtask

  task automatic test_data_read_l1();
    a_data_we = 1'b0; a_data_addr = 16'h0010; a_data_req = 1'b1;
    tick();
    vectors++;
    if ({a_mem_en, a_mem_we, a_mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      miscompares++;
      $display("FAIL rd1_access: en=%b we=%b addr=%h, want en=1 we=0 addr=0010",
               a_mem_en, a_mem_we, a_mem_addr);
    end
    tick();
    vectors++;
    if ({a_data_done, a_data_rdata} !== {1'b1, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL rd1_done: done=%b rdata=%h, want done=1 rdata=beef", a_data_done, a_data_rdata);
    end
    a_data_req = 1'b0;
    tick();
    vectors++;
    if ({a_data_done, a_mem_en, a_data_rdata} !== {1'b0, 1'b0, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL rd1_after: done=%b en=%b rdata=%h, want 0 0 beef", a_data_done, a_mem_en, a_data_rdata);
    end
    tick();
    $display("data read L=1 addr 0010 -> %h", a_data_rdata);
  endtask

  task automatic test_data_write();
    a_data_we = 1'b1; a_data_addr = 16'h0200; a_data_wdata = 16'h00A5; a_data_req = 1'b1;
    tick();
    vectors++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 16'h0200, 16'h00A5}) begin
      miscompares++;
      $display("FAIL wr_access: en=%b we=%b addr=%h wdata=%h, want 1 1 0200 00a5",
               a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    tick();
    vectors++;
    if ({a_data_done, a_mem_en, a_data_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL wr_done: done=%b en=%b rdata=%h, want 1 0 beef", a_data_done, a_mem_en, a_data_rdata);
    end
    a_data_req = 1'b0; a_data_we = 1'b0;
    tick();
    vectors++;
    if (a_data_done !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_pulse: done=%b in cycle 3, want 0", a_data_done);
    end
    tick();
    $display("data write L=1 addr 0200 <- 00a5");
  endtask

  task automatic test_fetch_l1();
    a_fetch_addr = 16'h0040; a_fetch_req = 1'b1;
    tick();
    vectors++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_fetch_done} !== {1'b1, 1'b0, 16'h0040, 1'b0}) begin
      miscompares++;
      $display("FAIL f1_word0: en=%b we=%b addr=%h done=%b, want 1 0 0040 0",
               a_mem_en, a_mem_we, a_mem_addr, a_fetch_done);
    end
    tick();
    vectors++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_fetch_done} !== {1'b1, 1'b0, 16'h0041, 1'b0}) begin
      miscompares++;
      $display("FAIL f1_word1: en=%b we=%b addr=%h done=%b, want 1 0 0041 0",
               a_mem_en, a_mem_we, a_mem_addr, a_fetch_done);
    end
    tick();
    vectors++;
    if ({a_fetch_done, a_fetch_instr} !== {1'b1, 26'h3FFFC00}) begin
      miscompares++;
      $display("FAIL f1_done: done=%b instr=%h, want 1 3fffc00", a_fetch_done, a_fetch_instr);
    end
    a_fetch_req = 1'b0;
    tick();
    vectors++;
    if ({a_fetch_done, a_fetch_instr} !== {1'b0, 26'h3FFFC00}) begin
      miscompares++;
      $display("FAIL f1_hold: done=%b instr=%h, want 0 3fffc00", a_fetch_done, a_fetch_instr);
    end
    tick();
    $display("fetch L=1 addr 0040 -> %h", a_fetch_instr);
  endtask

  task automatic test_data_read_l3();
    b_data_we = 1'b0; b_data_addr = 16'h0123; b_data_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      vectors++;
      if ({b_mem_en, b_data_done} !== {c == 1, c == 4}) begin
        miscompares++;
        $display("FAIL rd3_cycle%0d: en=%b done=%b, want %b %b", c, b_mem_en, b_data_done, c == 1, c == 4);
      end
      if (c == 4) begin
        vectors++;
        if (b_data_rdata !== 16'h5A5A) begin
          miscompares++;
          $display("FAIL rd3_data: rdata=%h, want 5a5a", b_data_rdata);
        end
        b_data_req = 1'b0;
      end
    end
    $display("data read L=3 addr 0123 -> %h", b_data_rdata);
  endtask

  // Shared by the plain fetch and the post-reset restart: fetch at FFFF, L=3
  task automatic test_fetch_wrap(input string tag);
    for (int c = 1; c <= 8; c++) begin
      tick();
      vectors++;
      if ({b_mem_en, b_mem_we, b_fetch_done} !== {(c == 1) || (c == 4), 1'b0, c == 7}) begin
        miscompares++;
        $display("FAIL %s_cycle%0d: en=%b we=%b done=%b, want %b 0 %b",
                 tag, c, b_mem_en, b_mem_we, b_fetch_done, (c == 1) || (c == 4), c == 7);
      end
      if (c == 1 || c == 4) begin
        vectors++;
        if (b_mem_addr !== ((c == 1) ? 16'hFFFF : 16'h0000)) begin
          miscompares++;
          $display("FAIL %s_addr%0d: addr=%h, want %h", tag, c, b_mem_addr,
                   (c == 1) ? 16'hFFFF : 16'h0000);
        end
      end
      if (c == 7) begin
        vectors++;
        if (b_fetch_instr !== 26'h048D3FF) begin
          miscompares++;
          $display("FAIL %s_instr: instr=%h, want 048d3ff", tag, b_fetch_instr);
        end
        b_fetch_req = 1'b0;
      end
    end
    $display("fetch L=3 (%s) addr ffff -> %h", tag, b_fetch_instr);
  endtask

  task automatic test_conflict();
    int  a_order[$];
    int  b_order[$];
    int  exp_order[4];
`ifdef MEM_PORT_ARB_RR_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_data_we = 1'b0; a_data_addr = 16'h0010; a_fetch_addr = 16'h0040;
    b_data_we = 1'b0; b_data_addr = 16'h0123; b_fetch_addr = 16'hFFFF;
    a_data_req = 1'b1; a_fetch_req = 1'b1;
    b_data_req = 1'b1; b_fetch_req = 1'b1;
    for (int c = 0; c < 80 && (a_order.size() < 4 || b_order.size() < 4); c++) begin
      tick();
      if (a_data_done)  begin a_order.push_back(0); $display("conflict a: data granted"); end
      if (a_fetch_done) begin a_order.push_back(1); $display("conflict a: fetch granted"); end
      if (b_data_done)  begin b_order.push_back(0); $display("conflict b: data granted"); end
      if (b_fetch_done) begin b_order.push_back(1); $display("conflict b: fetch granted"); end
    end
    a_data_req = 1'b0; a_fetch_req = 1'b0;
    b_data_req = 1'b0; b_fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= a_order.size() || a_order[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL conflict_a%0d: got %0d (of %0d grants), want %0d (1=fetch)",
                 i, (i < a_order.size()) ? a_order[i] : -1, a_order.size(), exp_order[i]);
      end
      vectors++;
      if (i >= b_order.size() || b_order[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL conflict_b%0d: got %0d (of %0d grants), want %0d (1=fetch)",
                 i, (i < b_order.size()) ? b_order[i] : -1, b_order.size(), exp_order[i]);
      end
    end
    repeat (20) tick();
  endtask

  task automatic test_reset_mid_fetch();
    b_fetch_addr = 16'hFFFF; b_fetch_req = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({b_fetch_done, b_fetch_instr, b_data_done, b_data_rdata, b_mem_en, b_mem_we,
         b_mem_addr, b_mem_wdata} !== 78'd0) begin
      miscompares++;
      $display("FAIL midreset_zero: instr=%h rdata=%h addr=%h en=%b, want all 0",
               b_fetch_instr, b_data_rdata, b_mem_addr, b_mem_en);
    end
    tick();
    reset = 1'b0;
    test_fetch_wrap("restart");
  endtask

  initial begin
    ram_a[16'h0010] = 16'hBEEF;
    ram_a[16'h0040] = 16'hFFFF;
    ram_a[16'h0041] = 16'hFC00;
    ram_b[16'hFFFF] = 16'h1234;
    ram_b[16'h0000] = 16'h03FF;
    ram_b[16'h0123] = 16'h5A5A;
    test_reset();
    test_data_read_l1();
    test_data_write();
    test_fetch_l1();
    test_data_read_l3();
    b_fetch_addr = 16'hFFFF; b_fetch_req = 1'b1;
    test_fetch_wrap("wrap");
    test_conflict();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 16-bit program/data RAM between the control unit's instruction fetch and its load/store path. A fetch returns a complete 26-bit instruction, assembled from two consecutive RAM words. A data access reads or writes one 16-bit word. One transaction is in flight at a time. All RAM-side signals are driven only by this block, and the block tolerates a RAM read latency fixed at build time.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from the `mem_en` cycle to the clock edge at which `mem_rdata` is valid; legal range 1–7.

Ports (all vectors `[0:N]`, bit 0 = MSB):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- fetch_req  in  1  fetch request; hold until `fetch_done`
- fetch_addr  in  16  word address of instruction high word
- fetch_done  out  1  one-cycle completion pulse
- fetch_instr  out  26  assembled instruction; valid with `fetch_done`, held until next fetch completes
- data_req  in  1  data request; hold until `data_done`
- data_we  in  1  1 = write, 0 = read
- data_addr  in  16  word address
- data_wdata  in  16  write data
- data_done  out  1  one-cycle completion pulse
- data_rdata  out  16  read data; valid with `data_done`, held until next data read completes
- mem_en  out  1  RAM access strobe, one cycle per access
- mem_we  out  1  RAM write enable, qualified by `mem_en`
- mem_addr  out  16  RAM address
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data

## Operation
- States: IDLE, D_ACC, D_WAIT, F_ACC0, F_WAIT0, F_ACC1, F_WAIT1, DONE.
- IDLE:
  - Samples requests and latches the winner's address, write flag and write data.
  - Data winner goes to D_ACC. Fetch winner goes to F_ACC0.
- Conflict rule (both requests high in IDLE): data wins. See Configuration.
- *_ACC states:
  - Assert `mem_en` for exactly one cycle.
  - `mem_we` = `data_we` in D_ACC, 0 in fetch states.
  - `mem_addr`/`mem_wdata` come from latched values.
- *_WAIT states:
  - A 3-bit counter spends MEM_LATENCY−1 cycles in the state; 0 cycles when MEM_LATENCY = 1.
  - `mem_rdata` is captured on the edge MEM_LATENCY cycles after the `mem_en` cycle began.
- Data write: skips D_WAIT and goes directly D_ACC → DONE. Writes are posted.
- Fetch:
  - Word 0 at `fetch_addr` → `fetch_instr[0:15]`.
  - Word 1 at `fetch_addr + 1` → `fetch_instr[16:25]` = `word1[6:15]`; `word1[0:5]` is discarded.
  - The address increment wraps mod 2^16 (0xFFFF → 0x0000).
- DONE:
  - Pulses the owner's `*_done` for one cycle, then goes to IDLE.
  - Requests are not sampled in DONE.
  - A requester that still holds `req` in the IDLE cycle that follows starts a new transaction.
- Dropping `req` mid-transaction is ignored: the access completes and `done` still pulses.
- `reset` (asynchronous, at any time):
  - State → IDLE; counter → 0.
  - All outputs → 0, including `fetch_instr` and `data_rdata`.
  - An in-flight access is abandoned; no `done` is issued.

## Timing
- Request seen in IDLE in cycle 0 → `mem_en` in cycle 1.
- Data read: `data_done` in cycle MEM_LATENCY+1; IDLE again in cycle MEM_LATENCY+2.
- Data write: `data_done` in cycle 2; IDLE in cycle 3.
- Fetch: second `mem_en` in cycle MEM_LATENCY+1; `fetch_done` in cycle 2·MEM_LATENCY+1.
- Every output is registered; no combinational path from inputs to outputs.
- `mem_en` is never high in two consecutive cycles when MEM_LATENCY > 1.

## Configuration
- `MEM_PORT_ARB_RR_EN`:
  - Defined: round-robin on conflict. A 1-bit last-grant flop is kept, and the requester not granted last wins. Reset value = data, so fetch wins the first conflict. Neither requester can be starved.
  - Undefined: fixed priority, data over fetch; no last-grant flop. Continuous data traffic starves fetch.

## Structure
- Shared package `calcu16_pkg`:
  - State enum.
  - `WORD_W` = 16, `INSTR_W` = 26.
  - `INSTR_LO_MSB` = 6, the index of `word1` bit mapped to `instr[16]`.
- One natural sub-module: `mem_arb_pick`. It contains the conflict-resolution logic plus the last-grant flop under `MEM_PORT_ARB_RR_EN`, and outputs a one-hot grant to the main FSM.

## Test plan
- Data read, MEM_LATENCY=1:
  - Stimulus: RAM[0x0010]=0xBEEF; `data_req` high in cycle 0.
  - Response: `mem_en` in cycle 1 with `mem_addr`=0x0010; `data_done` in cycle 2 with `data_rdata`=0xBEEF.
- Fetch with wrap, MEM_LATENCY=3:
  - Stimulus: RAM[0xFFFF]=0x1234, RAM[0x0000]=0x03FF; fetch at 0xFFFF.
  - Response: second `mem_addr`=0x0000; `fetch_instr`=0x048D3FF; `fetch_done` in cycle 7.
- Data write:
  - Stimulus: write 0x00A5 to 0x0200.
  - Response: `mem_en`=`mem_we`=1 in cycle 1 with `mem_wdata`=0x00A5; `data_done` in cycle 2; `mem_we` never high in fetch states.
- Conflict, both requests held continuously:
  - Without macro: data is granted every transaction.
  - With `MEM_PORT_ARB_RR_EN`: grant order fetch, data, fetch, data.
- Reset mid-fetch:
  - Stimulus: assert `reset` in F_WAIT0.
  - Response: all outputs 0 immediately; no `fetch_done`. After release, a held `fetch_req` restarts a full fetch from word 0.
